// File: rtl/usb_data_buffer.sv
// usb_data_buffer
//   Shared byte FIFO between the AHB-lite slave register block and the USB
//   protocol engines. The USB RX engine and the AHB slave both write into it.
//   The AHB slave and the USB TX engine both read from it. The head entry is
//   shown on both read ports. Occupancy and error pulses are registered.
//
// Ports
//   clk                   system clock, rising edge
//   n_rst                 synchronous active-low reset
//   clear                 flush request; empties the buffer
//   store_tx_data/tx_data AHB-side write strobe / byte
//   get_rx_data/rx_data   AHB-side read strobe / show-ahead head byte
//   store_rx_packet_data/rx_packet_data  USB RX write strobe / byte
//   get_tx_packet_data/tx_packet_data    USB TX read strobe / show-ahead byte
//   buffer_occupancy      entries held, 0..DEPTH
//   overflow              one-cycle pulse: a write was dropped
//   underflow             one-cycle pulse: a read was refused
module usb_data_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8,
  parameter int OCC_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             store_tx_data,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             get_rx_data,
  output logic [WIDTH-1:0] rx_data,
  input  logic             store_rx_packet_data,
  input  logic [WIDTH-1:0] rx_packet_data,
  input  logic             get_tx_packet_data,
  output logic [WIDTH-1:0] tx_packet_data,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             overflow,
  output logic             underflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [OCC_W-1:0] cnt_q, cnt_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic             wr_req, rd_req;
  logic             wr_ok, rd_ok;
  logic [WIDTH-1:0] wr_byte;
  logic [WIDTH-1:0] head;

  always_comb begin
    wr_req      = store_rx_packet_data | store_tx_data;
    rd_req      = get_rx_data | get_tx_packet_data;
    // RX engine wins when both writers strobe together.
    wr_byte     = store_rx_packet_data ? rx_packet_data : tx_data;
    // No fall-through: a read needs data already present before this edge.
    rd_ok       = rd_req && (cnt_q != '0) && !clear;
    // A full buffer still accepts a write when a read frees a slot this edge.
    wr_ok       = wr_req && ((cnt_q < FULL_CNT) || rd_ok) && !clear;

    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    cnt_d       = cnt_q;
    overflow_d  = 1'b0;
    underflow_d = 1'b0;

    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (wr_ok) wptr_d = wptr_q + PTR_W'(1);
      if (rd_ok) rptr_d = rptr_q + PTR_W'(1);
      if (wr_ok && !rd_ok) cnt_d = cnt_q + OCC_W'(1);
      else if (rd_ok && !wr_ok) cnt_d = cnt_q - OCC_W'(1);
      // A dropped TX byte (both writers) or a dropped write to full.
      overflow_d  = (store_rx_packet_data && store_tx_data) || (wr_req && !wr_ok);
      // Both readers collapse to one pop, or a read from empty.
      underflow_d = (get_rx_data && get_tx_packet_data) || (rd_req && !rd_ok);
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      if (wr_ok) mem_q[wptr_q] <= wr_byte;
    end
  end

  // Array is not reset, so mask the head while empty.
  assign head             = (cnt_q == '0) ? '0 : mem_q[rptr_q];
  assign rx_data          = head;
  assign tx_packet_data   = head;
  assign buffer_occupancy = cnt_q;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule

// File: tb/tb_usb_data_buffer.sv
module tb_usb_data_buffer;

  logic       clk;
  logic       n_rst;
  logic       clear;
  logic       store_tx_data;
  logic [7:0] tx_data;
  logic       get_rx_data;
  logic [7:0] rx_data;
  logic       store_rx_packet_data;
  logic [7:0] rx_packet_data;
  logic       get_tx_packet_data;
  logic [7:0] tx_packet_data;
  logic [6:0] buffer_occupancy;
  logic       overflow;
  logic       underflow;

  int n_cmp = 0;
  int n_err = 0;

  usb_data_buffer dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .clear                (clear),
    .store_tx_data        (store_tx_data),
    .tx_data              (tx_data),
    .get_rx_data          (get_rx_data),
    .rx_data              (rx_data),
    .store_rx_packet_data (store_rx_packet_data),
    .rx_packet_data       (rx_packet_data),
    .get_tx_packet_data   (get_tx_packet_data),
    .tx_packet_data       (tx_packet_data),
    .buffer_occupancy     (buffer_occupancy),
    .overflow             (overflow),
    .underflow            (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear = 0; store_tx_data = 0; tx_data = 0; get_rx_data = 0;
    store_rx_packet_data = 0; rx_packet_data = 0; get_tx_packet_data = 0;
  endtask

  task automatic flags_quiet(input string tag);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_unf"}, 32'(underflow), 0);
  endtask

  initial begin
    logic [7:0] t1 [3];
    t1[0] = 8'hA1; t1[1] = 8'hB2; t1[2] = 8'hC3;

    idle_inputs();
    n_rst = 0;
    step(); step();
    n_rst = 1;
    chk("rst_occ", 32'(buffer_occupancy), 0);
    chk("rst_rxd", 32'(rx_data), 0);
    chk("rst_txd", 32'(tx_packet_data), 0);
    flags_quiet("rst");

    // Three RX writes, three AHB reads with same-cycle data.
    for (int i = 0; i < 3; i++) begin
      store_rx_packet_data = 1; rx_packet_data = t1[i];
      step();
      chk("t1_occ_up", 32'(buffer_occupancy), 32'(i + 1));
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      get_rx_data = 1;
      chk("t1_rxd", 32'(rx_data), 32'(t1[i]));
      step();
      flags_quiet("t1");
    end
    idle_inputs();
    chk("t1_occ_end", 32'(buffer_occupancy), 0);

    // Fill to 64, overflow on 65th, drain.
    for (int i = 0; i < 64; i++) begin
      store_tx_data = 1; tx_data = 8'(i);
      step();
    end
    chk("t2_occ_full", 32'(buffer_occupancy), 64);
    chk("t2_no_ovf", 32'(overflow), 0);
    tx_data = 8'hFF;
    step();
    chk("t2_ovf", 32'(overflow), 1);
    chk("t2_occ_hold", 32'(buffer_occupancy), 64);
    idle_inputs();
    step();
    chk("t2_ovf_pulse", 32'(overflow), 0);
    for (int i = 0; i < 64; i++) begin
      get_tx_packet_data = 1;
      chk("t2_txd", 32'(tx_packet_data), 32'(i));
      step();
    end
    idle_inputs();
    chk("t2_occ_end", 32'(buffer_occupancy), 0);
    chk("t2_empty_txd", 32'(tx_packet_data), 0);
    chk("t2_unf", 32'(underflow), 0);

    // Full with simultaneous read+write, then drain across the wrap.
    for (int i = 0; i < 64; i++) begin
      store_rx_packet_data = 1; rx_packet_data = 8'(8'h80 + i);
      step();
    end
    idle_inputs();
    store_rx_packet_data = 1; rx_packet_data = 8'h55; get_rx_data = 1;
    chk("t3_head", 32'(rx_data), 32'h80);
    step();
    chk("t3_occ", 32'(buffer_occupancy), 64);
    flags_quiet("t3");
    idle_inputs();
    for (int i = 0; i < 63; i++) begin
      get_rx_data = 1;
      chk("t3_rxd", 32'(rx_data), 32'(8'h81 + i));
      step();
    end
    idle_inputs();
    chk("t3_last_occ", 32'(buffer_occupancy), 1);
    chk("t3_last", 32'(rx_data), 32'h55);
    get_rx_data = 1;
    step();
    idle_inputs();
    chk("t3_occ_end", 32'(buffer_occupancy), 0);

    // Read from empty with a same-cycle write: no fall-through.
    get_rx_data = 1; store_tx_data = 1; tx_data = 8'h77;
    step();
    idle_inputs();
    chk("t4_unf", 32'(underflow), 1);
    chk("t4_occ", 32'(buffer_occupancy), 1);
    chk("t4_rxd", 32'(rx_data), 32'h77);
    step();
    chk("t4_unf_pulse", 32'(underflow), 0);
    get_rx_data = 1;
    step();
    idle_inputs();
    chk("t4_occ_end", 32'(buffer_occupancy), 0);

    // Clear overrides every strobe, including error conditions.
    for (int i = 0; i < 10; i++) begin
      store_rx_packet_data = 1; rx_packet_data = 8'(8'h20 + i);
      step();
    end
    idle_inputs();
    chk("t5_occ_load", 32'(buffer_occupancy), 10);
    clear = 1; store_rx_packet_data = 1; rx_packet_data = 8'h99;
    store_tx_data = 1; tx_data = 8'h98; get_rx_data = 1; get_tx_packet_data = 1;
    step();
    idle_inputs();
    chk("t5_occ", 32'(buffer_occupancy), 0);
    chk("t5_rxd", 32'(rx_data), 0);
    flags_quiet("t5");
    step();
    chk("t5_occ_still", 32'(buffer_occupancy), 0);
    store_rx_packet_data = 1; rx_packet_data = 8'h12;
    step();
    idle_inputs();
    chk("t5_occ_new", 32'(buffer_occupancy), 1);
    chk("t5_rxd_new", 32'(rx_data), 32'h12);
    get_rx_data = 1;
    step();
    idle_inputs();

    // Both write strobes: RX byte kept, TX byte dropped, overflow pulse.
    store_rx_packet_data = 1; rx_packet_data = 8'h5A;
    store_tx_data = 1; tx_data = 8'hA5;
    step();
    idle_inputs();
    chk("t7_ovf", 32'(overflow), 1);
    chk("t7_occ", 32'(buffer_occupancy), 1);
    chk("t7_rxd", 32'(rx_data), 32'h5A);
    // Both read strobes: one pop plus underflow pulse.
    get_rx_data = 1; get_tx_packet_data = 1;
    step();
    idle_inputs();
    chk("t7_unf", 32'(underflow), 1);
    chk("t7_occ_end", 32'(buffer_occupancy), 0);

    // Reset mid-operation with strobes active.
    for (int i = 0; i < 5; i++) begin
      store_tx_data = 1; tx_data = 8'(8'h40 + i);
      step();
    end
    idle_inputs();
    chk("t6_occ_load", 32'(buffer_occupancy), 5);
    n_rst = 0; store_rx_packet_data = 1; rx_packet_data = 8'hEE;
    store_tx_data = 1; get_tx_packet_data = 1; get_rx_data = 1;
    step();
    idle_inputs();
    n_rst = 1;
    chk("t6_occ", 32'(buffer_occupancy), 0);
    flags_quiet("t6");
    chk("t6_rxd", 32'(rx_data), 0);
    chk("t6_txd", 32'(tx_packet_data), 0);
    store_tx_data = 1; tx_data = 8'h3C;
    step();
    idle_inputs();
    chk("t6_resume_occ", 32'(buffer_occupancy), 1);
    chk("t6_resume_txd", 32'(tx_packet_data), 32'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/usb_data_buffer.md
Name: usb_data_buffer

Overview:
- Shared byte FIFO between the AHB-lite slave register block and the USB protocol engines; it answers that block's get_rx_data, store_tx_data and clear requests.
- USB RX side writes received packet bytes in; AHB side reads them out through the slave.
- AHB side writes bytes for transmission in; USB TX side reads them out.
- Reports the live occupancy the slave exposes as its buffer-occupancy register.

Parameters:
- DEPTH, 64, entries; power of two, at least 4.
- WIDTH, 8, bits per entry.
- OCC_W, $clog2(DEPTH)+1, occupancy width (7 at default).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- n_rst  in  1  reset, synchronous, active-low; sampled only on clk rising edge.
- clear  in  1  flush request from the AHB slave; empties the buffer.
- store_tx_data  in  1  AHB-side write strobe.
- tx_data  in  WIDTH  AHB-side write byte.
- get_rx_data  in  1  AHB-side read strobe.
- rx_data  out  WIDTH  AHB-side read byte; show-ahead (head entry).
- store_rx_packet_data  in  1  USB RX write strobe.
- rx_packet_data  in  WIDTH  USB RX write byte.
- get_tx_packet_data  in  1  USB TX read strobe.
- tx_packet_data  out  WIDTH  USB TX read byte; show-ahead (head entry).
- buffer_occupancy  out  OCC_W  entries held, 0..DEPTH.
- overflow  out  1  one-cycle pulse: a write was dropped.
- underflow  out  1  one-cycle pulse: a read was refused.

Behaviour:
- Storage: DEPTH x WIDTH register array; write pointer wptr and read pointer rptr, each $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0; count register cnt (OCC_W bits).
- Reset (n_rst low at an edge): wptr=0, rptr=0, cnt=0, overflow=0, underflow=0. Array contents are not reset. Reset mid-operation discards all queued data and overrides every strobe that cycle.
- Outputs: rx_data = tx_packet_data = mem[rptr], combinational from registered state, with zero read latency. The slave captures rx_data in the same cycle it asserts get_rx_data.
  - When cnt==0 both data outputs are forced to 0; after reset they read 0.
- buffer_occupancy = cnt, registered; updates the cycle after the accepting edge.
- Write source select: wr_req = store_rx_packet_data | store_tx_data.
  - If both strobes are high, the RX byte is written, the TX byte is dropped, and overflow pulses.
- Read source select: rd_req = get_rx_data | get_tx_packet_data.
  - Both high counts as a single read (one pop) and pulses underflow.
- Write accept: wr_req && (cnt<DEPTH || rd_ok). Full with a simultaneous accepted read is accepted.
  - A write to full without a read is dropped and overflow pulses the next cycle.
- Read accept (rd_ok): rd_req && cnt>0. A read from empty is refused even when a write occurs in the same cycle (no fall-through); underflow pulses.
- Count update per edge: +1 for an accepted write only, -1 for an accepted read only, unchanged when both or neither are accepted. cnt never leaves 0..DEPTH.
- Accepted write: mem[wptr] <= byte, then wptr increments. Accepted read: rptr increments.
- clear: highest priority after reset. On the edge where clear=1, wptr=rptr=0 and cnt=0; all strobes that cycle are ignored; no overflow or underflow pulses.
- overflow and underflow are registered; each is high exactly one cycle after the offending edge.
- No internal FSM beyond pointer and count control; the design is a single always_ff block plus a combinational next-state block.

Test Plan:
- Reset, then write 0xA1, 0xB2, 0xC3 via store_rx_packet_data -> occupancy 1, 2, 3 on successive cycles. get_rx_data for 3 cycles returns rx_data 0xA1, 0xB2, 0xC3 in the same cycles; occupancy ends at 0, no error pulses.
- Fill with 64 store_tx_data writes (0x00..0x3F) -> occupancy 64. A 65th write (0xFF) gives overflow=1 for one cycle and occupancy stays 64. Draining via get_tx_packet_data yields 0x00..0x3F; 0xFF never appears.
- At occupancy 64, assert store_rx_packet_data=0x55 and get_rx_data together -> both accepted, occupancy stays 64, no overflow. After 63 more reads the final byte is 0x55, confirming wrap-around.
- Empty buffer: assert get_rx_data together with store_tx_data=0x77 -> underflow pulses, occupancy becomes 1, rx_data=0x77 next cycle.
- Load 10 bytes, then assert clear together with store_rx_packet_data -> occupancy 0 the next cycle, rx_data=0, no pulses. A new write of 0x12 reads back as 0x12.
- Load 5 bytes, then drive n_rst low for one edge while strobes are active -> occupancy 0, both flags 0, data outputs 0. Operation resumes normally afterwards.
